rx_rss_queue_map: RTL and testbench

RX_RSS_QUEUE_MAP -- requirements
Module: rx_rss_queue_map

---
 rtl/rx_rss_queue_map.sv | 129 ++++++++++++
 tb/tb_rx_rss_queue_map.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_rss_queue_map.sv
// RSS indirection-table lookup: maps a Toeplitz hash plus function id to an RX queue
// through a two-stage pipeline feeding a first-word-fall-through result FIFO.
module rx_rss_queue_map #(
    parameter int QUEUE_INDEX_WIDTH = 8,
    parameter int HASH_IDX_WIDTH    = 6,
    parameter int FUNC_SEL_WIDTH    = 2,
    parameter int FIFO_DEPTH        = 8
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [31:0]                              s_axis_hash,
    input  logic [3:0]                               s_axis_hash_type,
    input  logic [7:0]                               s_axis_function_id,
    input  logic                                     s_axis_hash_valid,
    output logic [QUEUE_INDEX_WIDTH-1:0]             m_axis_queue,
    output logic [31:0]                              m_axis_hash,
    output logic [3:0]                               m_axis_hash_type,
    output logic [7:0]                               m_axis_function_id,
    output logic                                     m_axis_valid,
    input  logic                                     m_axis_ready,
    input  logic                                     enable,
    input  logic [HASH_IDX_WIDTH-1:0]                hash_mask,
    input  logic [QUEUE_INDEX_WIDTH-1:0]             default_queue,
    input  logic                                     tbl_wr_en,
    input  logic [FUNC_SEL_WIDTH+HASH_IDX_WIDTH-1:0] tbl_wr_addr,
    input  logic [QUEUE_INDEX_WIDTH-1:0]             tbl_wr_data,
    output logic [31:0]                              drop_count
);

    localparam int ADDR_W    = FUNC_SEL_WIDTH + HASH_IDX_WIDTH;
    localparam int TBL_DEPTH = 1 << ADDR_W;
    localparam int FIFO_AW   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W   = QUEUE_INDEX_WIDTH + 32 + 4 + 8;
    localparam logic [FIFO_AW:0] PTR_ONE = 1;

    typedef logic [ENTRY_W-1:0] entry_t;

    // Result handshake: a result transfers on a rising edge where m_axis_valid and
    // m_axis_ready are both high; while valid is high and ready low the outputs hold.

    logic [QUEUE_INDEX_WIDTH-1:0] tbl [TBL_DEPTH];
    logic [ADDR_W-1:0]            lookup_addr;

    logic                         s1_valid;
    logic [31:0]                  s1_hash;
    logic [3:0]                   s1_type;
    logic [7:0]                   s1_fid;
    logic [QUEUE_INDEX_WIDTH-1:0] s1_entry;
    logic [QUEUE_INDEX_WIDTH-1:0] s2_queue;
    entry_t                       s2_entry;

    entry_t                       fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW:0]             wr_ptr;
    logic [FIFO_AW:0]             rd_ptr;
    logic                         fifo_empty;
    logic                         fifo_full;
    logic                         pop;
    logic                         push_ok;
    logic                         drop;

    assign lookup_addr = {s_axis_function_id[FUNC_SEL_WIDTH-1:0],
                          s_axis_hash[HASH_IDX_WIDTH-1:0] & hash_mask};

    // Table is deliberately not reset; a same-address write and read returns the old entry.
    always_ff @(posedge clk) begin
        if (tbl_wr_en) begin
            tbl[tbl_wr_addr] <= tbl_wr_data;
        end
        if (s_axis_hash_valid) begin
            s1_entry <= tbl[lookup_addr];
            s1_hash  <= s_axis_hash;
            s1_type  <= s_axis_hash_type;
            s1_fid   <= s_axis_function_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= s_axis_hash_valid;
        end
    end

    always_comb begin
        s2_queue = s1_entry;
        if (!enable || (s1_type == 4'd0)) begin
            s2_queue = default_queue;
        end
        s2_entry = {s2_queue, s1_hash, s1_type, s1_fid};
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign pop        = m_axis_valid && m_axis_ready;
    // A pop frees the head slot this cycle, so a push into a full FIFO can still land.
    assign push_ok    = s1_valid && (!fifo_full || pop);
    assign drop       = s1_valid && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            fifo_mem[wr_ptr[FIFO_AW-1:0]] <= s2_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_count <= 32'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (drop && (drop_count != 32'hFFFF_FFFF)) begin
                drop_count <= drop_count + 32'd1;
            end
        end
    end

    assign m_axis_valid = !fifo_empty;
    assign {m_axis_queue, m_axis_hash, m_axis_hash_type, m_axis_function_id} =
        fifo_mem[rd_ptr[FIFO_AW-1:0]];

endmodule

// File: tb/tb_rx_rss_queue_map.sv
// Randomized and directed bench for rx_rss_queue_map with a queue-based reference
// model and a scoreboard monitor that checks every result the DUT presents.
module tb_rx_rss_queue_map;

    localparam int QW    = 8;
    localparam int HW    = 6;
    localparam int FW    = 2;
    localparam int DEPTH = 8;
    localparam int W     = QW + 32 + 4 + 8;

    logic          clk;
    logic          rst_n;
    logic [31:0]   s_axis_hash;
    logic [3:0]    s_axis_hash_type;
    logic [7:0]    s_axis_function_id;
    logic          s_axis_hash_valid;
    logic [QW-1:0] m_axis_queue;
    logic [31:0]   m_axis_hash;
    logic [3:0]    m_axis_hash_type;
    logic [7:0]    m_axis_function_id;
    logic          m_axis_valid;
    logic          m_axis_ready;
    logic          enable;
    logic [HW-1:0] hash_mask;
    logic [QW-1:0] default_queue;
    logic          tbl_wr_en;
    logic [FW+HW-1:0] tbl_wr_addr;
    logic [QW-1:0] tbl_wr_data;
    logic [31:0]   drop_count;

    rx_rss_queue_map #(
        .QUEUE_INDEX_WIDTH(QW), .HASH_IDX_WIDTH(HW), .FUNC_SEL_WIDTH(FW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_hash(s_axis_hash), .s_axis_hash_type(s_axis_hash_type),
        .s_axis_function_id(s_axis_function_id), .s_axis_hash_valid(s_axis_hash_valid),
        .m_axis_queue(m_axis_queue), .m_axis_hash(m_axis_hash),
        .m_axis_hash_type(m_axis_hash_type), .m_axis_function_id(m_axis_function_id),
        .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
        .enable(enable), .hash_mask(hash_mask), .default_queue(default_queue),
        .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
        .drop_count(drop_count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a lookup remembers the table value seen at sampling time;
    // one edge later it resolves the queue and enters a bounded FIFO of results.
    logic [QW-1:0] tbl_model [256];
    int            occ = 0;
    logic [31:0]   m_drop = 0;
    bit            p_valid = 0;
    logic [31:0]   p_hash;
    logic [3:0]    p_type;
    logic [7:0]    p_fid;
    logic [QW-1:0] p_entry;
    logic [QW-1:0] m_q;
    bit            m_pop;
    int            m_addr;

    always @(posedge clk) begin
        if (!rst_n) begin
            occ = 0;
            exp_q.delete();
            m_drop = 0;
            p_valid = 0;
        end else begin
            m_pop = (occ > 0) && m_axis_ready;
            if (m_pop) occ--;
            if (p_valid) begin
                m_q = (!enable || p_type == 4'd0) ? default_queue : p_entry;
                if (occ < DEPTH) begin
                    exp_q.push_back({m_q, p_hash, p_type, p_fid});
                    occ++;
                end else if (m_drop != 32'hFFFF_FFFF) begin
                    m_drop = m_drop + 1;
                end
            end
            p_valid = s_axis_hash_valid;
            if (s_axis_hash_valid) begin
                m_addr  = int'(s_axis_function_id % 4) * 64 + int'(s_axis_hash[5:0] & hash_mask);
                p_entry = tbl_model[m_addr];
                p_hash  = s_axis_hash;
                p_type  = s_axis_hash_type;
                p_fid   = s_axis_function_id;
            end
        end
        if (tbl_wr_en) tbl_model[int'(tbl_wr_addr)] = tbl_wr_data;
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (mon_en) begin
            check("valid", m_axis_valid, (occ != 0));
            check("drop_count", drop_count, m_drop);
            if (m_axis_valid && m_axis_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    check("result", {m_axis_queue, m_axis_hash, m_axis_hash_type, m_axis_function_id},
                          exp_q.pop_front());
                end
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        s_axis_hash_valid = 1'b0;
        tbl_wr_en = 1'b0;
    endtask

    task automatic strobe(input logic [31:0] h, input logic [3:0] t, input logic [7:0] f);
        s_axis_hash = h;
        s_axis_hash_type = t;
        s_axis_function_id = f;
        s_axis_hash_valid = 1'b1;
    endtask

    task automatic tbl_write(input logic [7:0] a, input logic [QW-1:0] d);
        tbl_wr_addr = a;
        tbl_wr_data = d;
        tbl_wr_en = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        s_axis_hash = '0; s_axis_hash_type = '0; s_axis_function_id = '0; s_axis_hash_valid = 1'b0;
        m_axis_ready = 1'b1; enable = 1'b1; hash_mask = 6'h3F; default_queue = 8'd3;
        tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_data = '0;
        repeat (3) tick();
        check("reset_valid", m_axis_valid, 0);
        check("reset_drop", drop_count, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 256; i++) begin
            tbl_write(8'(i), (i == 8'h45) ? 8'd9 : (i == 8'h10) ? 8'd2 : 8'($urandom_range(0, 255)));
            tick();
        end

        // Fixed latency and lookup
        strobe(32'h0000_0045, 4'h5, 8'h01);
        tick();
        tick();
        check("lat_valid", m_axis_valid, 1);
        check("lat_queue", m_axis_queue, 9);
        check("lat_echo", {m_axis_hash, m_axis_hash_type, m_axis_function_id}, {32'h45, 4'h5, 8'h01});
        repeat (2) tick();

        // Bypass paths
        strobe(32'h0000_0045, 4'h0, 8'h01);
        tick();
        tick();
        check("bypass_nonip", m_axis_queue, 3);
        tick();
        enable = 1'b0;
        strobe(32'h0000_0045, 4'h1, 8'h01);
        tick();
        tick();
        check("bypass_disabled", m_axis_queue, 3);
        enable = 1'b1;
        tick();

        // Same-cycle write and lookup
        tbl_write(8'h10, 8'd7);
        strobe(32'h0000_0010, 4'h1, 8'h00);
        tick();
        tick();
        check("collide_old", m_axis_queue, 2);
        strobe(32'h0000_0010, 4'h1, 8'h00);
        tick();
        tick();
        check("collide_new", m_axis_queue, 7);
        tick();

        // Overflow with ready low
        m_axis_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            strobe(32'h100 + i, 4'h1, 8'(i));
            tick();
        end
        repeat (2) tick();
        check("ovf_drop", drop_count, 2);
        check("ovf_held", m_axis_valid, 1);
        m_axis_ready = 1'b1;
        repeat (10) tick();

        // Full FIFO with push and pop every cycle
        m_axis_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            strobe(32'h200 + i, 4'h4, 8'(i));
            tick();
        end
        repeat (2) tick();
        m_axis_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            strobe(32'h300 + i, 4'h8, 8'(i + 1));
            tick();
        end
        repeat (2) tick();
        check("full_pushpop_drop", drop_count, 2);
        repeat (10) tick();

        // Reset with a result in flight
        strobe(32'h0000_0045, 4'h1, 8'h01);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_valid", m_axis_valid, 0);
        check("midrst_drop", drop_count, 0);
        tick();
        check("midrst_valid2", m_axis_valid, 0);
        strobe(32'h0000_0045, 4'h1, 8'h01);
        tick();
        tick();
        check("midrst_table", m_axis_queue, 9);
        tick();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            m_axis_ready = ($urandom_range(0, 1) == 1);
            enable = ($urandom_range(0, 9) != 0);
            default_queue = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) hash_mask = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 9) < 7)
                strobe($urandom, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 4) == 0)
                tbl_write(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            tick();
        end

        hash_mask = 6'h3F;
        m_axis_ready = 1'b1;
        repeat (20) tick();
        check("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
